// File: rtl/resource_responder_pkg.sv
// Shared definitions for the resource responder: FSM encoding, descriptor layout
// and the offset-mask helper used by the lookup stage.
package resource_responder_pkg;

  localparam int RES_SIZE_LOG2_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } res_state_e;

  // Descriptor = {valid, base, size_log2}; base width follows the memory depth,
  // so it lives in its own array in the top and only the fixed fields are packed here.
  typedef struct packed {
    logic                           valid;
    logic [RES_SIZE_LOG2_WIDTH-1:0] size_log2;
  } res_desc_ctrl_t;

  function automatic logic [31:0] offset_mask(input logic [RES_SIZE_LOG2_WIDTH-1:0] size_log2);
    return (32'd1 << size_log2) - 32'd1;
  endfunction

endpackage

// File: rtl/resource_mem.sv
// Single-port sample memory with synchronous write and one-cycle registered read,
// written so synthesis maps it onto block RAM.
module resource_mem #(
  parameter int data_width = 16,
  parameter int depth      = 4096,
  parameter int addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/resource_responder.sv
// Target side of the resource read/write request interface: descriptor table,
// address translation and a four-state handshake FSM in front of the sample memory.
module resource_responder
  import resource_responder_pkg::*;
#(
  parameter int data_width   = 16,
  parameter int handle_width = 8,
  parameter int n_resources  = 16,
  parameter int mem_depth    = 4096,
  parameter int addr_width   = $clog2(mem_depth)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           read_req,
  input  logic                           write_req,
  input  logic [handle_width-1:0]        handle,
  input  logic [data_width-1:0]          arg_a,
  input  logic [data_width-1:0]          arg_b,
  output logic signed [data_width-1:0]   data_out,
  output logic                           read_ready,
  output logic                           write_ack,
  input  logic                           cfg_write,
  input  logic [handle_width-1:0]        cfg_handle,
  input  logic [addr_width-1:0]          cfg_base,
  input  logic [RES_SIZE_LOG2_WIDTH-1:0] cfg_size_log2,
  output logic                           busy,
  output logic                           err
);

  localparam int idx_width = $clog2(n_resources);

  res_state_e state;

  logic [handle_width-1:0] lat_handle;
  logic [data_width-1:0]   lat_arg_a;
  logic [data_width-1:0]   lat_arg_b;
  logic                    op_is_write;
  logic                    req_void;
  logic [addr_width-1:0]   acc_addr;

  res_desc_ctrl_t        desc_ctrl [n_resources];
  logic [addr_width-1:0] desc_base [n_resources];

  logic                  cfg_ok;
  logic [idx_width-1:0]  cfg_idx;
  logic                  lookup_handle_ok;
  logic [idx_width-1:0]  lookup_idx;
  res_desc_ctrl_t        lookup_ctrl;
  logic [31:0]           lookup_offset;
  logic [addr_width-1:0] lookup_addr;
  logic                  lookup_ok;
  logic                  active_req;
  logic                  mem_we;
  logic [data_width-1:0] mem_rdata;

  assign cfg_ok  = 32'(cfg_handle) < 32'(n_resources);
  assign cfg_idx = cfg_handle[idx_width-1:0];

  // Lookup reads the registered table, so a same-cycle cfg write lands after it.
  assign lookup_handle_ok = 32'(lat_handle) < 32'(n_resources);
  assign lookup_idx       = lat_handle[idx_width-1:0];
  assign lookup_ctrl      = desc_ctrl[lookup_idx];
  assign lookup_offset    = 32'(lat_arg_a) & offset_mask(lookup_ctrl.size_log2);
  assign lookup_addr      = addr_width'(32'(desc_base[lookup_idx]) + lookup_offset);
  assign lookup_ok        = lookup_handle_ok && lookup_ctrl.valid;

  assign active_req = op_is_write ? write_req : read_req;
  assign mem_we     = (state == ACCESS) && op_is_write && !req_void && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < n_resources; i++) begin
        desc_ctrl[i] <= '0;
      end
    end else if (cfg_write && cfg_ok) begin
      desc_ctrl[cfg_idx].valid     <= 1'b1;
      desc_ctrl[cfg_idx].size_log2 <= cfg_size_log2;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_write && cfg_ok) begin
      desc_base[cfg_idx] <= cfg_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((state == IDLE && read_req && write_req) ||
                 (state == LOOKUP && !lookup_ok) ||
                 (cfg_write && !cfg_ok)) begin
      err <= 1'b1;
    end
  end

  // The first ACK cycle captures the memory output; later ACK cycles hold until the req drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      read_ready  <= 1'b0;
      write_ack   <= 1'b0;
      data_out    <= '0;
      op_is_write <= 1'b0;
      req_void    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (read_req || write_req) begin
            lat_handle  <= handle;
            lat_arg_a   <= arg_a;
            lat_arg_b   <= arg_b;
            op_is_write <= write_req;
            state       <= LOOKUP;
            busy        <= 1'b1;
          end
        end
        LOOKUP: begin
          acc_addr <= lookup_addr;
          req_void <= !lookup_ok;
          state    <= ACCESS;
        end
        ACCESS: begin
          state <= ACK;
        end
        ACK: begin
          if (!read_ready && !write_ack) begin
            if (op_is_write) begin
              write_ack <= 1'b1;
            end else begin
              read_ready <= 1'b1;
              data_out   <= req_void ? '0 : $signed(mem_rdata);
            end
          end else if (!active_req) begin
            read_ready <= 1'b0;
            write_ack  <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  resource_mem #(
    .data_width(data_width),
    .depth     (mem_depth),
    .addr_width(addr_width)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (acc_addr),
    .wdata(lat_arg_b),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_resource_responder.sv
// Self-checking bench for resource_responder: table-driven transactions through a
// scoreboard queue, plus hand-written sequences for the multi-cycle corner cases.
module tb_resource_responder;

  localparam int DW = 16;
  localparam int HW = 8;
  localparam int AW = 12;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 read_req;
  logic                 write_req;
  logic [HW-1:0]        handle;
  logic [DW-1:0]        arg_a;
  logic [DW-1:0]        arg_b;
  logic signed [DW-1:0] data_out;
  logic                 read_ready;
  logic                 write_ack;
  logic                 cfg_write;
  logic [HW-1:0]        cfg_handle;
  logic [AW-1:0]        cfg_base;
  logic [4:0]           cfg_size_log2;
  logic                 busy;
  logic                 err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        is_write;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic        is_write;
    logic [7:0]  h;
    logic [15:0] a;
    logic [15:0] b;
    int          hold;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  resource_responder dut (
    .clk          (clk),
    .reset        (reset),
    .read_req     (read_req),
    .write_req    (write_req),
    .handle       (handle),
    .arg_a        (arg_a),
    .arg_b        (arg_b),
    .data_out     (data_out),
    .read_ready   (read_ready),
    .write_ack    (write_ack),
    .cfg_write    (cfg_write),
    .cfg_handle   (cfg_handle),
    .cfg_base     (cfg_base),
    .cfg_size_log2(cfg_size_log2),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    read_req   = 1'b0;
    write_req  = 1'b0;
    cfg_write  = 1'b0;
    handle     = '0;
    arg_a      = '0;
    arg_b      = '0;
    cfg_handle = '0;
    cfg_base   = '0;
    cfg_size_log2 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic applyCfg(input logic [7:0] h, input logic [11:0] base, input logic [4:0] size_log2);
    cfg_handle    = h;
    cfg_base      = base;
    cfg_size_log2 = size_log2;
    cfg_write     = 1'b1;
    tick();
    cfg_write = 1'b0;
  endtask

  // One full request/ack handshake; optionally rewrites the descriptor while in LOOKUP.
  task automatic applyStimulus(input logic is_write, input logic both, input logic [7:0] h,
                               input logic [15:0] a, input logic [15:0] b, input int hold,
                               input logic [15:0] exp_data, input logic exp_err,
                               input logic inject_cfg, input logic [11:0] inj_base,
                               input string name);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    logic [1:0] exp_kind;
    e.is_write = is_write || both;
    e.data     = exp_data;
    exp_q.push_back(e);
    handle    = h;
    arg_a     = a;
    arg_b     = b;
    write_req = is_write || both;
    read_req  = !is_write || both;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      tick();
      if (inject_cfg && c == 1) begin
        cfg_handle    = h;
        cfg_base      = inj_base;
        cfg_size_log2 = 5'd4;
        cfg_write     = 1'b1;
      end
      if (c == 2) cfg_write = 1'b0;
      if (read_ready || write_ack) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    cfg_write = 1'b0;
    checkOutput({name, "_ack_seen"}, 32'(seen), 32'd1);
    got = exp_q.pop_front();
    exp_kind = got.is_write ? 2'b10 : 2'b01;
    if (seen) begin
      checkOutput({name, "_latency"}, 32'(lat), 32'd4);
      checkOutput({name, "_ack_kind"}, 32'({write_ack, read_ready}), 32'(exp_kind));
      if (!got.is_write) checkOutput({name, "_data"}, 32'($unsigned(data_out)), 32'(got.data));
      for (int k = 0; k < hold; k++) begin
        tick();
        checkOutput({name, "_hold_ack"}, 32'({write_ack, read_ready}), 32'(exp_kind));
        if (!got.is_write) checkOutput({name, "_hold_data"}, 32'($unsigned(data_out)), 32'(got.data));
      end
    end
    read_req  = 1'b0;
    write_req = 1'b0;
    tick();
    checkOutput({name, "_drop"}, 32'({write_ack, read_ready, busy}), 32'd0);
    checkOutput({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 8'd3, 16'd5,     16'h1234, 0, 16'h0000};
    vecs[1] = '{1'b0, 8'd3, 16'd21,    16'h0000, 4, 16'h1234};
    vecs[2] = '{1'b1, 8'd5, 16'h001F,  16'h5A5A, 0, 16'h0000};
    vecs[3] = '{1'b0, 8'd5, 16'hFFFF,  16'h0000, 1, 16'h5A5A};
    vecs[4] = '{1'b1, 8'd6, 16'h0D05,  16'h7777, 0, 16'h0000};
    vecs[5] = '{1'b0, 8'd6, 16'h0D05,  16'h0000, 0, 16'h7777};
    vecs[6] = '{1'b0, 8'd2, 16'h0005,  16'h0000, 0, 16'h7777};
    vecs[7] = '{1'b0, 8'd2, 16'h100F,  16'h0000, 2, 16'h5A5A};
    vecs[8] = '{1'b0, 8'd3, 16'h0105,  16'h0000, 0, 16'h1234};

    doReset();
    checkOutput("reset_outputs", 32'({read_ready, write_ack, busy, err}), 32'd0);
    checkOutput("reset_data_out", 32'($unsigned(data_out)), 32'd0);

    applyCfg(8'd3, 12'h100, 5'd4);
    applyCfg(8'd5, 12'hFF0, 5'd5);
    applyCfg(8'd6, 12'h300, 5'd20);
    applyCfg(8'd2, 12'h000, 5'd12);
    checkOutput("cfg_valid_no_err", 32'(err), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].is_write, 1'b0, vecs[i].h, vecs[i].a, vecs[i].b, vecs[i].hold,
                    vecs[i].exp_data, 1'b0, 1'b0, 12'h000, $sformatf("vec%0d", i));
    end

    // Both requests high: treated as a write and flagged.
    applyStimulus(1'b1, 1'b1, 8'd3, 16'd0, 16'hBEEF, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "both_req");
    applyStimulus(1'b0, 1'b0, 8'd3, 16'd0, 16'h0000, 0, 16'hBEEF, 1'b1, 1'b0, 12'h000, "both_readback");

    // Descriptor rewrite during LOOKUP must not affect the in-flight request.
    applyStimulus(1'b0, 1'b0, 8'd3, 16'd5, 16'h0000, 0, 16'h1234, 1'b1, 1'b1, 12'h200, "cfg_in_lookup");
    applyStimulus(1'b1, 1'b0, 8'd3, 16'd5, 16'h4321, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "new_base_write");
    applyCfg(8'd3, 12'h100, 5'd4);
    applyStimulus(1'b0, 1'b0, 8'd3, 16'd5, 16'h0000, 0, 16'h1234, 1'b1, 1'b0, 12'h000, "old_base_intact");
    applyCfg(8'd3, 12'h200, 5'd4);
    applyStimulus(1'b0, 1'b0, 8'd3, 16'd5, 16'h0000, 0, 16'h4321, 1'b1, 1'b0, 12'h000, "new_base_read");

    // Void writes are acknowledged without touching memory.
    applyCfg(8'd3, 12'h100, 5'd4);
    applyStimulus(1'b1, 1'b0, 8'd19, 16'd5, 16'hDEAD, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "void_write_h19");
    applyStimulus(1'b1, 1'b0, 8'd20, 16'd5, 16'hDEAD, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "void_write_h20");
    applyStimulus(1'b0, 1'b0, 8'd3, 16'd5, 16'h0000, 0, 16'h1234, 1'b1, 1'b0, 12'h000, "mem_unchanged");
    applyStimulus(1'b0, 1'b0, 8'd19, 16'd5, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "void_read_h19");

    // Each error source in isolation after a fresh reset.
    doReset();
    checkOutput("reset2_err_clear", 32'(err), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'd7, 16'd5, 16'h0000, 1, 16'h0000, 1'b1, 1'b0, 12'h000, "unconfig_read_h7");
    doReset();
    applyStimulus(1'b1, 1'b0, 8'd20, 16'd5, 16'hDEAD, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "write_h20_err");
    doReset();
    applyCfg(8'd16, 12'h123, 5'd3);
    checkOutput("cfg_bad_handle_err", 32'(err), 32'd1);

    // Reset while the write is in ACCESS aborts it.
    doReset();
    applyCfg(8'd3, 12'h100, 5'd4);
    handle    = 8'd3;
    arg_a     = 16'd5;
    arg_b     = 16'hAAAA;
    write_req = 1'b1;
    tick();
    checkOutput("abort_busy_lookup", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    write_req = 1'b0;
    checkOutput("abort_no_ack", 32'({write_ack, read_ready}), 32'd0);
    checkOutput("abort_busy_low", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("abort_still_idle", 32'({write_ack, read_ready, busy, err}), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'd3, 16'd5, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 12'h000, "desc_cleared_read");

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
